projectile_mover: RTL and testbench
===================================

// Module: projectile_mover
// PURPOSE
//   Upstream stage of the projectile collision checkers: owns one projectile's flight and drives the
//   x_cord/y_cord pair that the collision checker compares against the character position.
//   Accepts a fire request, steps the projectile once per frame_tick in one of four directions, and
//   retires it on a collision flag (hit) or on reaching the screen edge (miss). A cooldown follows
//   each retirement before the next shot.
// PARAMETERS
//   X_MAX     319  largest legal x coordinate (9-bit)
//   Y_MAX     239  largest legal y coordinate (9-bit)
//   STEP      2    pixels moved per frame_tick, 1..15
//   COOLDOWN  30   frame_ticks spent in COOLDOWN after a hit or miss, 1..255
//   PARK      511  x_cord/y_cord value driven while no projectile is in flight
// PORTS
//   clock       in   1  system clock, all state on rising edge
//   resetn      in   1  asynchronous, active-low reset
//   frame_tick  in   1  one-cycle pulse per video frame
//   fire        in   1  launch request, accepted only while ready=1
//   fire_x      in   9  launch x, latched on accept
//   fire_y      in   9  launch y, latched on accept
//   fire_dir    in   2  00 right(+x), 01 left(-x), 10 down(+y), 11 up(-y), latched on accept
//   hit_flag    in   3  collision checker flag; any nonzero value = hit
//   x_cord      out  9  projectile x, registered
//   y_cord      out  9  projectile y, registered
//   active      out  1  1 while in FLIGHT
//   ready       out  1  1 while in IDLE (decoded from state)
//   hit_pulse   out  1  one-cycle pulse on retirement by hit
//   miss_pulse  out  1  one-cycle pulse on retirement at an edge
// BEHAVIOUR
//   Reset (async, resetn=0):
//     - state=IDLE, x_cord=y_cord=PARK, active=0, ready=1, pulses=0, cooldown count=0.
//   IDLE:
//     - fire=1 accepted on the same edge.
//     - fire_x/fire_y clamped to X_MAX/Y_MAX and loaded into x_cord/y_cord; dir latched.
//     - Next state FLIGHT; active=1 from the next cycle.
//   FLIGHT, evaluated in this priority order:
//     1. First FLIGHT cycle: hit_flag is ignored (collision stage has 1-cycle registered latency).
//     2. hit_flag!=0: hit_pulse=1 for one cycle, x/y=PARK, go to COOLDOWN.
//        Hit wins over a coincident frame_tick or edge condition; no move that cycle.
//     3. frame_tick=1 and the next step would leave [0,X_MAX]x[0,Y_MAX]:
//        - right: x+STEP>X_MAX; left: x<STEP; down: y+STEP>Y_MAX; up: y<STEP.
//        - miss_pulse=1, x/y=PARK, go to COOLDOWN. No wrap-around and no partial step.
//     4. frame_tick=1 otherwise: advance the axis selected by dir by STEP; the other axis holds.
//        Compute in 10 bits so the compare never overflows.
//   COOLDOWN:
//     - Counter loads COOLDOWN on entry and decrements on each frame_tick.
//     - Exit to IDLE on the cycle the counter decrements 1->0; ready=1 from the following cycle.
//     - active=0 and x/y=PARK throughout.
//   fire is ignored outside IDLE. There is no queueing; a request must be reasserted.
//   hit_pulse and miss_pulse are never high in the same cycle.
//   Reset mid-flight: immediate return to the reset values, with no pulse.
// TESTING
//   - Reset: resetn=0 mid-FLIGHT -> x/y=511, active=0, ready=1, no pulses.
//   - Launch right: fire (10,100,00), STEP=2, 5 ticks -> x=20, y=100, active=1.
//   - Edge miss: fire (316,50,00) -> tick 1: x=318; tick 2: miss_pulse, x=511, COOLDOWN.
//     After 30 ticks -> ready=1.
//   - Hit: hit_flag=3'b100 in the 3rd FLIGHT cycle together with frame_tick -> hit_pulse, no move,
//     x/y=511; fire during COOLDOWN ignored.
//   - First-cycle mask: hit_flag=3'b100 only in the first FLIGHT cycle -> no hit, flight continues.
//   - Clamp/up: fire (400,300,11) -> x=319, y=239; 119 ticks -> y=1; next tick -> miss_pulse.

Source files
------------

// File: rtl/projectile_mover.sv
// Single-projectile flight controller: launches on fire, steps once per frame_tick,
// retires on a collision flag or at the screen edge, then waits out a cooldown.
module projectile_mover #(
  parameter int unsigned X_MAX    = 319,
  parameter int unsigned Y_MAX    = 239,
  parameter int unsigned STEP     = 2,
  parameter int unsigned COOLDOWN = 30,
  parameter int unsigned PARK     = 511
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [8:0] fire_x,
  input  logic [8:0] fire_y,
  input  logic [1:0] fire_dir,
  input  logic [2:0] hit_flag,
  output logic [8:0] x_cord,
  output logic [8:0] y_cord,
  output logic       active,
  output logic       ready,
  output logic       hit_pulse,
  output logic       miss_pulse
);

  // state    | meaning
  // S_IDLE   | no projectile, waiting for fire
  // S_FLIGHT | projectile moving, watching hit_flag and edges
  // S_COOL   | retired, counting frame_ticks before next shot
  typedef enum logic [1:0] {S_IDLE, S_FLIGHT, S_COOL} state_t;

  localparam logic [8:0] X_MAX9  = 9'(X_MAX);
  localparam logic [8:0] Y_MAX9  = 9'(Y_MAX);
  localparam logic [9:0] X_MAX10 = 10'(X_MAX);
  localparam logic [9:0] Y_MAX10 = 10'(Y_MAX);
  localparam logic [8:0] STEP9   = 9'(STEP);
  localparam logic [9:0] STEP10  = 10'(STEP);
  localparam logic [8:0] PARK9   = 9'(PARK);
  localparam logic [7:0] COOL8   = 8'(COOLDOWN);

  state_t     r_state, w_state_nxt;
  logic [8:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic [1:0] r_dir, w_dir_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_first, w_first_nxt;
  logic       r_hit, r_miss, w_hit_nxt, w_miss_nxt;
  logic [9:0] w_x_up, w_y_up;
  logic       w_edge;

  // 10-bit sums keep the edge compare free of wrap-around
  assign w_x_up = {1'b0, r_x} + STEP10;
  assign w_y_up = {1'b0, r_y} + STEP10;

  always_comb begin
    w_edge = 1'b0;
    case (r_dir)
      2'b00: w_edge = (w_x_up > X_MAX10);
      2'b01: w_edge = ({1'b0, r_x} < STEP10);
      2'b10: w_edge = (w_y_up > Y_MAX10);
      2'b11: w_edge = ({1'b0, r_y} < STEP10);
      default: w_edge = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = 1'b0;
    w_hit_nxt   = 1'b0;
    w_miss_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fire) begin
          w_x_nxt     = (fire_x > X_MAX9) ? X_MAX9 : fire_x;
          w_y_nxt     = (fire_y > Y_MAX9) ? Y_MAX9 : fire_y;
          w_dir_nxt   = fire_dir;
          w_first_nxt = 1'b1;
          w_state_nxt = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
        // collision flag lags position by one cycle, so the launch cycle is masked
        if (!r_first && (hit_flag != 3'b000)) begin
          w_hit_nxt   = 1'b1;
          w_x_nxt     = PARK9;
          w_y_nxt     = PARK9;
          w_cnt_nxt   = COOL8;
          w_state_nxt = S_COOL;
        end else if (frame_tick) begin
          if (w_edge) begin
            w_miss_nxt  = 1'b1;
            w_x_nxt     = PARK9;
            w_y_nxt     = PARK9;
            w_cnt_nxt   = COOL8;
            w_state_nxt = S_COOL;
          end else begin
            case (r_dir)
              2'b00: w_x_nxt = w_x_up[8:0];
              2'b01: w_x_nxt = r_x - STEP9;
              2'b10: w_y_nxt = w_y_up[8:0];
              2'b11: w_y_nxt = r_y - STEP9;
              default: w_x_nxt = r_x;
            endcase
          end
        end
      end
      S_COOL: begin
        if (frame_tick) begin
          w_cnt_nxt = (r_cnt != 8'd0) ? r_cnt - 8'd1 : 8'd0;
          if (r_cnt <= 8'd1) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_x     <= PARK9;
      r_y     <= PARK9;
      r_dir   <= 2'b00;
      r_cnt   <= 8'd0;
      r_first <= 1'b0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
      r_first <= w_first_nxt;
      r_hit   <= w_hit_nxt;
      r_miss  <= w_miss_nxt;
    end
  end

  assign x_cord     = r_x;
  assign y_cord     = r_y;
  assign active     = (r_state == S_FLIGHT);
  assign ready      = (r_state == S_IDLE);
  assign hit_pulse  = r_hit;
  assign miss_pulse = r_miss;

endmodule

// File: tb/tb_projectile_mover.sv
// Directed bench for projectile_mover: expected output vectors go through a scoreboard
// queue and are compared against the registered outputs 1ns after each rising edge.
module tb_projectile_mover;

  logic       clock = 1'b0;
  logic       resetn;
  logic       frame_tick, fire;
  logic [8:0] fire_x, fire_y;
  logic [1:0] fire_dir;
  logic [2:0] hit_flag;
  logic [8:0] x_cord, y_cord;
  logic       active, ready, hit_pulse, miss_pulse;

  typedef struct {
    string       tag;
    logic [21:0] v;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  projectile_mover dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .fire(fire),
    .fire_x(fire_x), .fire_y(fire_y), .fire_dir(fire_dir), .hit_flag(hit_flag),
    .x_cord(x_cord), .y_cord(y_cord), .active(active), .ready(ready),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  always #5 clock = ~clock;

  // one clock with the given inputs; returns 1ns after the rising edge
  task automatic cyc(input logic tk, input logic f, input logic [8:0] fx, input logic [8:0] fy,
                     input logic [1:0] d, input logic [2:0] hf);
    @(negedge clock);
    frame_tick = tk; fire = f; fire_x = fx; fire_y = fy; fire_dir = d; hit_flag = hf;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 9'd0, 9'd0, 2'b00, 3'b000);
  endtask

  task automatic tick_cyc();
    cyc(1'b1, 1'b0, 9'd0, 9'd0, 2'b00, 3'b000);
  endtask

  task automatic expect_out(input string tag, input logic [8:0] x, input logic [8:0] y,
                            input logic a, input logic r, input logic h, input logic m);
    exp_t e;
    e.tag = tag;
    e.v   = {x, y, a, r, h, m};
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [21:0] obs;
    e   = sb.pop_front();
    obs = {x_cord, y_cord, active, ready, hit_pulse, miss_pulse};
    vectors++;
    assert (obs === e.v) else begin
      miscompares++;
      $error("FAIL %s: observed x=%0d y=%0d act=%b rdy=%b hit=%b miss=%b, expected x=%0d y=%0d act=%b rdy=%b hit=%b miss=%b",
             e.tag, obs[21:13], obs[12:4], obs[3], obs[2], obs[1], obs[0],
             e.v[21:13], e.v[12:4], e.v[3], e.v[2], e.v[1], e.v[0]);
    end
  endtask

  task automatic chk(input string tag, input logic [8:0] x, input logic [8:0] y,
                     input logic a, input logic r, input logic h, input logic m);
    expect_out(tag, x, y, a, r, h, m);
    check_out();
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("reset_async", 9'd511, 9'd511, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  int ex;
  int ey;

  initial begin
    resetn = 1'b0; frame_tick = 1'b0; fire = 1'b0;
    fire_x = '0; fire_y = '0; fire_dir = '0; hit_flag = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", 9'd511, 9'd511, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    resetn = 1'b1;

    // launch right, 5 ticks
    cyc(1'b0, 1'b1, 9'd10, 9'd100, 2'b00, 3'b000);
    chk("launch_right", 9'd10, 9'd100, 1'b1, 1'b0, 1'b0, 1'b0);
    ex = 10;
    for (int i = 0; i < 5; i++) begin
      tick_cyc();
      ex += 2;
      chk("move_right", 9'(ex), 9'd100, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle_cyc();
    chk("hold_no_tick", 9'd20, 9'd100, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    idle_cyc();
    chk("after_reset", 9'd511, 9'd511, 1'b0, 1'b1, 1'b0, 1'b0);

    // edge miss on the right then full cooldown
    cyc(1'b0, 1'b1, 9'd316, 9'd50, 2'b00, 3'b000);
    chk("launch_edge", 9'd316, 9'd50, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_cyc();
    chk("edge_step", 9'd318, 9'd50, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_cyc();
    chk("edge_miss", 9'd511, 9'd511, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cyc();
    chk("miss_one_cycle", 9'd511, 9'd511, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 29; i++) tick_cyc();
    chk("cool_29", 9'd511, 9'd511, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_cyc();
    chk("cool_30_ready", 9'd511, 9'd511, 1'b0, 1'b1, 1'b0, 1'b0);

    // hit in 3rd flight cycle together with a tick; fire in cooldown ignored
    cyc(1'b0, 1'b1, 9'd50, 9'd60, 2'b00, 3'b000);
    chk("launch_hit", 9'd50, 9'd60, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cyc();
    idle_cyc();
    chk("pre_hit", 9'd50, 9'd60, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 9'd0, 9'd0, 2'b00, 3'b100);
    chk("hit_pulse", 9'd511, 9'd511, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 9'd20, 9'd20, 2'b01, 3'b000);
    chk("fire_in_cool", 9'd511, 9'd511, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 30; i++) tick_cyc();
    chk("hit_cool_done", 9'd511, 9'd511, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cyc();
    chk("no_queued_fire", 9'd511, 9'd511, 1'b0, 1'b1, 1'b0, 1'b0);

    // first-cycle hit mask, moving down
    cyc(1'b0, 1'b1, 9'd100, 9'd100, 2'b10, 3'b000);
    chk("launch_down", 9'd100, 9'd100, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 9'd0, 9'd0, 2'b00, 3'b100);
    chk("first_mask", 9'd100, 9'd100, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_cyc();
    chk("move_down", 9'd100, 9'd102, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 9'd0, 9'd0, 2'b00, 3'b001);
    chk("hit_lsb", 9'd511, 9'd511, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();

    // clamped launch moving up until the top edge
    cyc(1'b0, 1'b1, 9'd400, 9'd300, 2'b11, 3'b000);
    chk("clamp", 9'd319, 9'd239, 1'b1, 1'b0, 1'b0, 1'b0);
    ey = 239;
    for (int i = 0; i < 119; i++) begin
      tick_cyc();
      ey -= 2;
      if (i == 0) chk("move_up", 9'd319, 9'(ey), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("up_y1", 9'd319, 9'(ey), 1'b1, 1'b0, 1'b0, 1'b0);
    tick_cyc();
    chk("up_miss", 9'd511, 9'd511, 1'b0, 1'b0, 1'b0, 1'b1);

    // left edge with coincident tick on exact boundary x==STEP
    do_reset();
    cyc(1'b0, 1'b1, 9'd4, 9'd7, 2'b01, 3'b000);
    tick_cyc();
    chk("left_step", 9'd2, 9'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_cyc();
    chk("left_to_zero", 9'd0, 9'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_cyc();
    chk("left_miss", 9'd511, 9'd511, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
